pc_ifid_stage: RTL

PC_IFID_STAGE -- requirements
Module: pc_ifid_stage

---
 rtl/pc_ifid_stage_pkg.sv | 27 ++
 rtl/pc_ifid_stage_if_id_reg.sv | 40 ++++
 rtl/pc_ifid_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pc_ifid_stage_pkg.sv
// Shared pipeline definitions for the fetch stage.
//   fetch_state_t    : fetch controller states
//   DEFAULT_RESET_PC : PC loaded on reset
//   DEFAULT_NOP_INST : instruction word used for bubbles and flushes
//   pc_plus4         : sequential PC increment, wraps modulo 2^32
//   align_pc         : forces a redirect target onto a word boundary
package pc_ifid_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HELD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_ifid_stage_if_id_reg.sv
// IF/ID pipeline register with flush and stall.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : load a bubble {0, NOP_INST, 0}; wins over load
//   load          : capture {pc_in, inst_in, 1}
//   pc_in/inst_in : PC+4 and instruction word of the incoming instruction
//   if_id_pc/if_id_inst/if_id_valid : register contents
// With neither flush nor load the register holds (stall).
module if_id_reg
  import pc_ifid_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_pc    <= 32'h0;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      if_id_pc    <= 32'h0;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end else if (load) begin
      if_id_pc    <= pc_in;
      if_id_inst  <= inst_in;
      if_id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_ifid_stage.sv
// PC register, fetch controller and IF/ID register.
//   clk, rst       : clock, asynchronous active-high reset
//   if_rst, npc_in : redirect from the hazard unit (flush IF/ID, jump to npc_in)
//   if_stall       : hold PC and IF/ID
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//   if_id_pc/if_id_inst/if_id_valid        : IF/ID register outputs
//   fetch_busy     : draining a request that a redirect made stale
// FETCH issues a request every cycle. An ack during a stall parks the word
// in the hold buffer (HELD, no request) until the stall lifts. A redirect
// while a request is still unanswered must keep that request stable until
// it completes, so the old address is kept in drain_addr and the returned
// word is dropped (DRAIN).
module pc_ifid_stage
  import pc_ifid_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rst,
  input  logic        if_stall,
  input  logic [31:0] npc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        fetch_busy
);

  fetch_state_t state, state_nxt;

  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic [31:0] pc_inc;
  logic [31:0] hold_q;
  logic [31:0] drain_addr_q;

  logic        ifid_flush;
  logic        ifid_load;
  logic [31:0] ifid_inst;
  logic        hold_capture;
  logic        drain_capture;

  assign pc_inc = pc_plus4(pc_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        if (if_rst)                    state_nxt = imem_ack ? ST_FETCH : ST_DRAIN;
        else if (imem_ack && if_stall) state_nxt = ST_HELD;
      end
      ST_HELD: begin
        if (if_rst || !if_stall) state_nxt = ST_FETCH;
      end
      ST_DRAIN: begin
        if (imem_ack) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Output and datapath control
  always_comb begin
    imem_req      = (state != ST_HELD) && !rst;
    imem_addr     = (state == ST_DRAIN) ? drain_addr_q : pc_q;
    fetch_busy    = (state == ST_DRAIN);
    ifid_flush    = 1'b0;
    ifid_load     = 1'b0;
    ifid_inst     = imem_rdata;
    pc_nxt        = pc_q;
    hold_capture  = 1'b0;
    drain_capture = 1'b0;
    case (state)
      ST_FETCH: begin
        if (if_rst) begin
          ifid_flush    = 1'b1;
          pc_nxt        = align_pc(npc_in);
          drain_capture = !imem_ack;
        end else if (imem_ack && !if_stall) begin
          ifid_load = 1'b1;
          pc_nxt    = pc_inc;
        end else if (imem_ack) begin
          hold_capture = 1'b1;
        end else if (!if_stall) begin
          ifid_flush = 1'b1;
        end
      end
      ST_HELD: begin
        if (if_rst) begin
          ifid_flush = 1'b1;
          pc_nxt     = align_pc(npc_in);
        end else if (!if_stall) begin
          ifid_load = 1'b1;
          ifid_inst = hold_q;
          pc_nxt    = pc_inc;
        end
      end
      ST_DRAIN: begin
        // IF/ID is already a bubble here; keep it that way regardless of stall.
        ifid_flush = 1'b1;
        if (if_rst) pc_nxt = align_pc(npc_in);
      end
      default: ifid_flush = 1'b1;
    endcase
  end

  // PC, hold buffer and drain address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      hold_q       <= 32'h0;
      drain_addr_q <= 32'h0;
    end else begin
      pc_q <= pc_nxt;
      if (hold_capture)   hold_q <= imem_rdata;
      else if (if_rst)    hold_q <= 32'h0;
      if (drain_capture)  drain_addr_q <= pc_q;
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (ifid_flush),
    .load        (ifid_load),
    .pc_in       (pc_inc),
    .inst_in     (ifid_inst),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid)
  );

endmodule
